// File: rtl/wb_regs_pkg.sv
// Shared widths, constants and the WB-entry type for the write-back stage and register file.
package wb_regs_pkg;

  localparam int RDATA_WIDTH      = 32;
  localparam int RADDR_WIDTH      = 5;
  localparam int ADDR_WIDTH       = 32;
  localparam int DEFAULT_RF_DEPTH = 32;

  typedef logic [RDATA_WIDTH-1:0] data_t;
  typedef logic [RADDR_WIDTH-1:0] raddr_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  localparam data_t  ZERO          = '0;
  localparam raddr_t ZERO_REG      = '0;
  localparam logic   WRITE_DISABLE = 1'b0;

  typedef struct packed {
    logic   valid;
    logic   we;
    raddr_t waddr;
    data_t  wdata;
    addr_t  inst_addr;
  } wb_entry_t;

  localparam wb_entry_t WB_BUBBLE = '{
    valid:     1'b0,
    we:        WRITE_DISABLE,
    waddr:     ZERO_REG,
    wdata:     ZERO,
    inst_addr: '0
  };

  // A pending WB write takes precedence over the array so decode sees it a cycle early.
  function automatic data_t read_port(raddr_t raddr, wb_entry_t wb, data_t rf_data);
    data_t result;
    result = rf_data;
    if (raddr == ZERO_REG) begin
      result = ZERO;
    end else if (wb.we && wb.valid && (wb.waddr == raddr)) begin
      result = wb.wdata;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_regs_if.sv
// Execute/decode-facing bundle of the write-back stage; directions named from the stage's view.
interface wb_regs_if
  import wb_regs_pkg::*;
#(
  parameter int CNT_WIDTH = 32
);

  logic                 valid_i;
  logic                 reg_we_i;
  raddr_t               reg_waddr_i;
  data_t                reg_wdata_i;
  addr_t                inst_addr_i;
  logic                 stall_i;
  logic                 flush_i;
  raddr_t               raddr1_i;
  raddr_t               raddr2_i;
  data_t                rdata1_o;
  data_t                rdata2_o;
  logic                 wb_valid_o;
  logic                 wb_we_o;
  raddr_t               wb_waddr_o;
  data_t                wb_wdata_o;
  addr_t                wb_inst_addr_o;
  logic [CNT_WIDTH-1:0] retire_cnt_o;

  modport master (
    output valid_i, reg_we_i, reg_waddr_i, reg_wdata_i, inst_addr_i,
    output stall_i, flush_i, raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o,
    input  wb_valid_o, wb_we_o, wb_waddr_o, wb_wdata_o, wb_inst_addr_o,
    input  retire_cnt_o
  );

  modport slave (
    input  valid_i, reg_we_i, reg_waddr_i, reg_wdata_i, inst_addr_i,
    input  stall_i, flush_i, raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o,
    output wb_valid_o, wb_we_o, wb_waddr_o, wb_wdata_o, wb_inst_addr_o,
    output retire_cnt_o
  );

endinterface

// File: rtl/wb_regs_regfile.sv
// Architectural register file: one write port, two combinational read ports, x0 hard-wired to zero.
module wb_regs_regfile
  import wb_regs_pkg::*;
#(
  parameter int RF_DEPTH = DEFAULT_RF_DEPTH
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   we_i,
  input  raddr_t waddr_i,
  input  data_t  wdata_i,
  input  raddr_t raddr1_i,
  input  raddr_t raddr2_i,
  output data_t  rdata1_o,
  output data_t  rdata2_o
);

  data_t rf_q [RF_DEPTH];
  data_t rf_d [RF_DEPTH];

  // NOTE: the whole array is copied first so every element has a value on every path; no latches.
  always_comb begin
    rf_d = rf_q;
    if (we_i && (waddr_i != ZERO_REG)) begin
      rf_d[waddr_i] = wdata_i;
    end
  end

  // NOTE: the array is reset because software may read a register before writing it and the
  // architecture promises zero; a plain RAM macro would not give that. Sequential state uses <=
  // so every flop samples the pre-edge value regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_q <= '{default: ZERO};
    end else begin
      rf_q <= rf_d;
    end
  end

  assign rdata1_o = (raddr1_i == ZERO_REG) ? ZERO : rf_q[raddr1_i];
  assign rdata2_o = (raddr2_i == ZERO_REG) ? ZERO : rf_q[raddr2_i];

endmodule

// File: rtl/wb_regs.sv
// Write-back stage: WB pipeline register, commit gating, read-port bypass and retire counter.
module wb_regs
  import wb_regs_pkg::*;
#(
  parameter int RF_DEPTH  = DEFAULT_RF_DEPTH,
  parameter int CNT_WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_regs_if.slave     bus
);

  wb_entry_t            wb_q;
  wb_entry_t            wb_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 commit;
  data_t                rf_rdata1;
  data_t                rf_rdata2;

  // Flush beats stall: a flushed slot is never held.
  always_comb begin
    wb_d = wb_q;
    if (bus.flush_i) begin
      wb_d = WB_BUBBLE;
    end else if (!bus.stall_i) begin
      wb_d.valid     = bus.valid_i;
      wb_d.we        = bus.reg_we_i & bus.valid_i;
      wb_d.waddr     = bus.reg_waddr_i;
      wb_d.wdata     = bus.reg_wdata_i;
      wb_d.inst_addr = bus.inst_addr_i;
    end
  end

  // Stall gates both commit and retirement, so a stalled entry is counted exactly once.
  always_comb begin
    commit = wb_q.we && (wb_q.waddr != ZERO_REG) && !bus.stall_i && !rst_i;
    cnt_d  = cnt_q;
    if (wb_q.valid && !bus.stall_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q  <= WB_BUBBLE;
      cnt_q <= '0;
    end else begin
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  wb_regs_regfile #(
    .RF_DEPTH (RF_DEPTH)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (commit),
    .waddr_i  (wb_q.waddr),
    .wdata_i  (wb_q.wdata),
    .raddr1_i (bus.raddr1_i),
    .raddr2_i (bus.raddr2_i),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  assign bus.rdata1_o       = read_port(bus.raddr1_i, wb_q, rf_rdata1);
  assign bus.rdata2_o       = read_port(bus.raddr2_i, wb_q, rf_rdata2);
  assign bus.wb_valid_o     = wb_q.valid;
  assign bus.wb_we_o        = wb_q.we;
  assign bus.wb_waddr_o     = wb_q.waddr;
  assign bus.wb_wdata_o     = wb_q.wdata;
  assign bus.wb_inst_addr_o = wb_q.inst_addr;
  assign bus.retire_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wb_regs.sv
// Bench for wb_regs: directed scenarios plus randomized traffic against an architectural model.
module tb_wb_regs;
  import wb_regs_pkg::*;

  logic clk;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  wb_regs_if #(.CNT_WIDTH(32)) bus ();
  wb_regs_if #(.CNT_WIDTH(4))  bus_s ();

  wb_regs #(.RF_DEPTH(32), .CNT_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  // Narrow-counter copy sharing the same stimulus, used to reach counter wrap quickly.
  wb_regs #(.RF_DEPTH(32), .CNT_WIDTH(4)) dut_s (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_s.slave)
  );

  assign bus_s.valid_i     = bus.valid_i;
  assign bus_s.reg_we_i    = bus.reg_we_i;
  assign bus_s.reg_waddr_i = bus.reg_waddr_i;
  assign bus_s.reg_wdata_i = bus.reg_wdata_i;
  assign bus_s.inst_addr_i = bus.inst_addr_i;
  assign bus_s.stall_i     = bus.stall_i;
  assign bus_s.flush_i     = bus.flush_i;
  assign bus_s.raddr1_i    = bus.raddr1_i;
  assign bus_s.raddr2_i    = bus.raddr2_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: register values, the instruction waiting in WB, and retirements.
  data_t       m_rf [32];
  bit          m_valid;
  bit          m_we;
  raddr_t      m_waddr;
  data_t       m_wdata;
  addr_t       m_pc;
  int unsigned m_cnt;

  function automatic data_t m_read(raddr_t a);
    if (a == 0) return 0;
    if (m_valid && m_we && m_waddr == a) return m_wdata;
    return m_rf[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_valid = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0;
      m_cnt   = 0;
      return;
    end
    if (!bus.stall_i) begin
      if (m_we && m_waddr != 0) m_rf[m_waddr] = m_wdata;
      if (m_valid) m_cnt = m_cnt + 1;
    end
    if (bus.flush_i) begin
      m_valid = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0;
    end else if (!bus.stall_i) begin
      m_valid = bus.valid_i;
      m_we    = bus.valid_i && bus.reg_we_i;
      m_waddr = bus.reg_waddr_i;
      m_wdata = bus.reg_wdata_i;
      m_pc    = bus.inst_addr_i;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input raddr_t a, input data_t d,
                       input addr_t pc, input logic st, input logic fl);
    bus.valid_i     = v;
    bus.reg_we_i    = we;
    bus.reg_waddr_i = a;
    bus.reg_wdata_i = d;
    bus.inst_addr_i = pc;
    bus.stall_i     = st;
    bus.flush_i     = fl;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 5'd4, 32'h1111_2222, 32'h40, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (bus.wb_valid_o !== 1'b0 || bus.wb_we_o !== 1'b0 || bus.wb_waddr_o !== 5'd0 ||
        bus.wb_wdata_o !== 32'h0 || bus.wb_inst_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_wb: got v=%b we=%b a=%0d d=%h pc=%h, want all zero",
               bus.wb_valid_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o, bus.wb_inst_addr_o);
    end
    tests_run++;
    if (bus.retire_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %0d, want 0", bus.retire_cnt_o);
    end
    for (int a = 0; a < 32; a++) begin
      bus.raddr1_i = raddr_t'(a);
      bus.raddr2_i = raddr_t'(31 - a);
      #1;
      tests_run++;
      if (bus.rdata1_o !== 32'h0 || bus.rdata2_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_rf x%0d: got %h/%h, want 0/0", a, bus.rdata1_o, bus.rdata2_o);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_write_bypass();
    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h100, 1'b0, 1'b0);
    bus.raddr1_i = 5'd5;
    step();
    tests_run++;
    if (bus.wb_wdata_o !== 32'hDEAD_BEEF || bus.wb_valid_o !== 1'b1 || bus.wb_inst_addr_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL wb_load: got d=%h v=%b pc=%h, want DEADBEEF/1/100",
               bus.wb_wdata_o, bus.wb_valid_o, bus.wb_inst_addr_o);
    end
    tests_run++;
    if (bus.rdata1_o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL bypass_x5: got %h, want DEADBEEF", bus.rdata1_o);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (bus.rdata1_o !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL array_x5: got %h, want DEADBEEF", bus.rdata1_o);
    end
    tests_run++;
    if (bus.retire_cnt_o !== 32'd1) begin
      tests_failed++;
      $display("FAIL cnt_after_x5: got %0d, want 1", bus.retire_cnt_o);
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 5'd0, 32'h1234_5678, 32'h104, 1'b0, 1'b0);
    bus.raddr1_i = 5'd0;
    step();
    tests_run++;
    if (bus.rdata1_o !== 32'h0 || bus.wb_we_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL x0_bypass: got rd=%h we=%b, want 0/1", bus.rdata1_o, bus.wb_we_o);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (bus.rdata1_o !== 32'h0 || bus.retire_cnt_o !== 32'd2) begin
      tests_failed++;
      $display("FAIL x0_commit: got rd=%h cnt=%0d, want 0/2", bus.rdata1_o, bus.retire_cnt_o);
    end
  endtask

  task automatic test_stall();
    int unsigned c0;
    drive(1'b1, 1'b1, 5'd7, 32'hA, 32'h200, 1'b0, 1'b0);
    bus.raddr2_i = 5'd7;
    step();
    c0 = m_cnt;
    drive(1'b1, 1'b1, 5'd8, 32'hBB, 32'h204, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.wb_waddr_o !== 5'd7 || bus.wb_wdata_o !== 32'hA || bus.wb_inst_addr_o !== 32'h200 ||
          bus.retire_cnt_o !== c0 || bus.rdata2_o !== 32'hA) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got a=%0d d=%h pc=%h cnt=%0d rd=%h, want 7/A/200/%0d/A",
                 i, bus.wb_waddr_o, bus.wb_wdata_o, bus.wb_inst_addr_o, bus.retire_cnt_o, bus.rdata2_o, c0);
      end
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (bus.retire_cnt_o !== c0 + 1 || bus.rdata2_o !== 32'hA || bus.wb_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: got cnt=%0d rd=%h v=%b, want %0d/A/0",
               bus.retire_cnt_o, bus.rdata2_o, bus.wb_valid_o, c0 + 1);
    end
  endtask

  task automatic test_flush();
    int unsigned c0;
    c0 = m_cnt;
    drive(1'b1, 1'b1, 5'd9, 32'h55, 32'h300, 1'b0, 1'b1);
    bus.raddr1_i = 5'd9;
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (bus.wb_valid_o !== 1'b0 || bus.rdata1_o !== 32'h0 || bus.retire_cnt_o !== c0) begin
      tests_failed++;
      $display("FAIL flush: got v=%b rd=%h cnt=%0d, want 0/0/%0d",
               bus.wb_valid_o, bus.rdata1_o, bus.retire_cnt_o, c0);
    end
    step();
    tests_run++;
    if (bus.rdata1_o !== 32'h0 || bus.retire_cnt_o !== c0) begin
      tests_failed++;
      $display("FAIL flush_after: got rd=%h cnt=%0d, want 0/%0d", bus.rdata1_o, bus.retire_cnt_o, c0);
    end
  endtask

  task automatic test_flush_stall();
    int unsigned c0;
    drive(1'b1, 1'b1, 5'd11, 32'h77, 32'h400, 1'b0, 1'b0);
    bus.raddr1_i = 5'd11;
    step();
    c0 = m_cnt;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (bus.wb_valid_o !== 1'b0 || bus.rdata1_o !== 32'h0 || bus.retire_cnt_o !== c0) begin
      tests_failed++;
      $display("FAIL flush_stall_discard: got v=%b rd=%h cnt=%0d, want 0/0/%0d",
               bus.wb_valid_o, bus.rdata1_o, bus.retire_cnt_o, c0);
    end
    step();
    tests_run++;
    if (bus.rdata1_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL flush_stall_x11: got %h, want 0", bus.rdata1_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), raddr_t'($urandom_range(0, 7)),
            $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      bus.raddr1_i = raddr_t'($urandom_range(0, 7));
      bus.raddr2_i = ($urandom_range(0, 3) == 0) ? raddr_t'($urandom_range(0, 31))
                                                 : raddr_t'($urandom_range(0, 7));
      step();
      tests_run++;
      if (bus.wb_valid_o !== m_valid || bus.wb_we_o !== m_we || bus.wb_waddr_o !== m_waddr ||
          bus.wb_wdata_o !== m_wdata || bus.wb_inst_addr_o !== m_pc) begin
        tests_failed++;
        $display("FAIL rand_wb[%0d]: got v=%b we=%b a=%0d d=%h pc=%h, want %b/%b/%0d/%h/%h", n,
                 bus.wb_valid_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o, bus.wb_inst_addr_o,
                 m_valid, m_we, m_waddr, m_wdata, m_pc);
      end
      tests_run++;
      if (bus.rdata1_o !== m_read(bus.raddr1_i) || bus.rdata2_o !== m_read(bus.raddr2_i)) begin
        tests_failed++;
        $display("FAIL rand_read[%0d]: x%0d=%h x%0d=%h, want %h/%h", n, bus.raddr1_i, bus.rdata1_o,
                 bus.raddr2_i, bus.rdata2_o, m_read(bus.raddr1_i), m_read(bus.raddr2_i));
      end
      tests_run++;
      if (bus.retire_cnt_o !== m_cnt || bus_s.retire_cnt_o !== m_cnt[3:0]) begin
        tests_failed++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d, want %0d/%0d", n,
                 bus.retire_cnt_o, bus_s.retire_cnt_o, m_cnt, m_cnt[3:0]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    drive(1'b1, 1'b0, 5'd1, 32'h0, 32'h500, 1'b0, 1'b0);
    step();
    while (m_cnt[3:0] != 4'hF && guard < 40) begin
      step();
      guard++;
    end
    tests_run++;
    if (guard >= 40 || bus_s.retire_cnt_o !== 4'hF) begin
      tests_failed++;
      $display("FAIL wrap_setup: got %0d after %0d cycles, want 15", bus_s.retire_cnt_o, guard);
    end
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    tests_run++;
    if (bus_s.retire_cnt_o !== 4'h0 || bus.retire_cnt_o !== m_cnt) begin
      tests_failed++;
      $display("FAIL wrap: got %0d/%0d, want 0/%0d", bus_s.retire_cnt_o, bus.retire_cnt_o, m_cnt);
    end
    step();
  endtask

  task automatic test_reset_pending();
    drive(1'b1, 1'b1, 5'd3, 32'hCAFE_F00D, 32'h600, 1'b0, 1'b0);
    bus.raddr1_i = 5'd3;
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (bus.wb_valid_o !== 1'b0 || bus.wb_we_o !== 1'b0 || bus.wb_waddr_o !== 5'd0 ||
        bus.wb_wdata_o !== 32'h0 || bus.wb_inst_addr_o !== 32'h0 || bus.retire_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_pending_wb: got v=%b we=%b a=%0d d=%h pc=%h cnt=%0d, want all zero",
               bus.wb_valid_o, bus.wb_we_o, bus.wb_waddr_o, bus.wb_wdata_o, bus.wb_inst_addr_o,
               bus.retire_cnt_o);
    end
    step();
    tests_run++;
    if (bus.rdata1_o !== 32'h0 || bus.retire_cnt_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_pending_x3: got rd=%h cnt=%0d, want 0/0", bus.rdata1_o, bus.retire_cnt_o);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.raddr1_i = 5'd0;
    bus.raddr2_i = 5'd0;
    foreach (m_rf[i]) m_rf[i] = 0;
    m_valid = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0; m_cnt = 0;
    #2;
    test_reset();
    test_write_bypass();
    test_x0();
    test_stall();
    test_flush();
    test_flush_stall();
    test_random();
    test_wrap();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
